// File: rtl/scale_arbiter_pkg.sv
// Shared types and constants for the scale_arbiter slice.
// The arbiter, its picker and its bus interface all import this package.
package scale_arbiter_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Requester IDs always need at least one bit, even for a single requester.
    function automatic int idWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scale_arbiter_if.sv
// Requester-side bus of scale_arbiter: request/ack payload plus the ready/valid result channel.
// The arbiter uses the slave modport and the requesters use the master modport.
interface scale_arbiter_if
    import scale_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = 4,
    parameter int MAX_WIDTH = 12
);
    localparam int ID_W = idWidth(NUM_REQ);

    logic [NUM_REQ-1:0]                 req;
    logic [NUM_REQ*LANES*IN_WIDTH-1:0]  req_vec;
    logic [NUM_REQ*MAX_WIDTH-1:0]       req_max;
    logic [NUM_REQ-1:0]                 ack;
    logic                               resp_valid;
    logic                               resp_ready;
    logic [ID_W-1:0]                    resp_id;
    logic [LANES*OUT_WIDTH-1:0]         resp_vec;

    modport master (
        output req, req_vec, req_max, resp_ready,
        input  ack, resp_valid, resp_id, resp_vec
    );

    modport slave (
        input  req, req_vec, req_max, resp_ready,
        output ack, resp_valid, resp_id, resp_vec
    );

endinterface

// File: rtl/scale_rr_pick.sv
// Combinational round-robin picker: grants the first set request after i_pointer, wrapping around.
module scale_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
)(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_pointer,
    output logic               o_grant_valid,
    output logic [ID_W-1:0]    o_grant_id
);

    int w_dist;
    int w_bestDist;

    // Each requester's distance past the pointer; the closest active one wins.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_id    = '0;
        w_dist        = 0;
        w_bestDist    = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = (j + NUM_REQ - 1 - int'(i_pointer)) % NUM_REQ;
            if (i_req[j] && (w_dist < w_bestDist)) begin
                w_bestDist    = w_dist;
                o_grant_valid = 1'b1;
                o_grant_id    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/scale_arbiter.sv
// Round-robin front end sharing one vector_scale among NUM_REQ requesters.
// It latches the winner's payload, runs start/done with a watchdog and returns the tagged result.
module scale_arbiter
    import scale_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = 4,
    parameter int MAX_WIDTH = 12,
    parameter int TIMEOUT   = 16
)(
    input  logic                       clk,
    input  logic                       reset,
    scale_arbiter_if.slave             bus,
    output logic                       busy,
    output logic                       err_timeout,
    output logic                       sc_start,
    output logic [LANES*IN_WIDTH-1:0]  sc_V_in,
    output logic [MAX_WIDTH-1:0]       sc_max_value,
    input  logic                       sc_done,
    input  logic [LANES*OUT_WIDTH-1:0] sc_V_out
);

    localparam int ID_W  = idWidth(NUM_REQ);
    localparam int VEC_W = LANES * IN_WIDTH;
    localparam int RES_W = LANES * OUT_WIDTH;
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t               r_state;
    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      r_id;
    logic [NUM_REQ-1:0]   r_ack;
    logic                 r_respValid;
    logic [ID_W-1:0]      r_respId;
    logic [RES_W-1:0]     r_respVec;
    logic                 r_busy;
    logic                 r_err;
    logic                 r_scStart;
    logic [VEC_W-1:0]     r_scVIn;
    logic [MAX_WIDTH-1:0] r_scMax;
    logic [TMR_W-1:0]     r_timer;

    logic                 w_grantValid;
    logic [ID_W-1:0]      w_grantId;
    logic [VEC_W-1:0]     w_grantVec;
    logic [MAX_WIDTH-1:0] w_grantMax;

    scale_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req         (bus.req),
        .i_pointer     (r_ptr),
        .o_grant_valid (w_grantValid),
        .o_grant_id    (w_grantId)
    );

    // Payload mux for the requester the picker selected.
    always_comb begin
        w_grantVec = '0;
        w_grantMax = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grantId == ID_W'(i)) begin
                w_grantVec = bus.req_vec[i*VEC_W +: VEC_W];
                w_grantMax = bus.req_max[i*MAX_WIDTH +: MAX_WIDTH];
            end
        end
    end

    // Outputs are registered on the edge entering each state, so ack/sc_start land in ISSUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= ID_W'(NUM_REQ - 1);
            r_id        <= '0;
            r_ack       <= '0;
            r_respValid <= 1'b0;
            r_respId    <= '0;
            r_respVec   <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_scStart   <= 1'b0;
            r_scVIn     <= '0;
            r_scMax     <= '0;
            r_timer     <= '0;
        end else begin
            r_ack     <= '0;
            r_scStart <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grantValid) begin
                        r_state          <= ST_ISSUE;
                        r_id             <= w_grantId;
                        r_ptr            <= w_grantId;
                        r_scVIn          <= w_grantVec;
                        r_scMax          <= w_grantMax;
                        r_ack[w_grantId] <= 1'b1;
                        r_scStart        <= 1'b1;
                        r_timer          <= '0;
                        r_busy           <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the last watchdog cycle still completes normally.
                    if (sc_done) begin
                        r_respVec   <= sc_V_out;
                        r_respId    <= r_id;
                        r_respValid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (r_timer == TMR_LAST) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        r_respValid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack        = r_ack;
    assign bus.resp_valid = r_respValid;
    assign bus.resp_id    = r_respId;
    assign bus.resp_vec   = r_respVec;
    assign busy           = r_busy;
    assign err_timeout    = r_err;
    assign sc_start       = r_scStart;
    assign sc_V_in        = r_scVIn;
    assign sc_max_value   = r_scMax;

endmodule

// File: tb/tb_scale_arbiter.sv
// Self-checking bench for scale_arbiter with a behavioural vector_scale stand-in.
// Expected grants and results come from a round-robin pointer model and lane-wise scaling arithmetic.
module tb_scale_arbiter;
    import scale_arbiter_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int IN_WIDTH  = 12;
    localparam int OUT_WIDTH = 4;
    localparam int MAX_WIDTH = 12;
    localparam int TIMEOUT   = 16;
    localparam int VEC_W     = LANES * IN_WIDTH;
    localparam int RES_W     = LANES * OUT_WIDTH;
    localparam int OUT_MAX   = (1 << OUT_WIDTH) - 1;

    logic                 clk;
    logic                 reset;
    logic                 busy;
    logic                 err_timeout;
    logic                 sc_start;
    logic [VEC_W-1:0]     sc_V_in;
    logic [MAX_WIDTH-1:0] sc_max_value;
    logic                 sc_done;
    logic [RES_W-1:0]     sc_V_out;

    logic                 scStub;
    int                   scCnt;
    int                   testCount;
    int                   failCount;
    int                   refPtr;
    logic [RES_W-1:0]     lastRespVec;

    scale_arbiter_if #(
        .NUM_REQ   (NUM_REQ),
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .MAX_WIDTH (MAX_WIDTH)
    ) bus ();

    scale_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .MAX_WIDTH (MAX_WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .sc_start     (sc_start),
        .sc_V_in      (sc_V_in),
        .sc_max_value (sc_max_value),
        .sc_done      (sc_done),
        .sc_V_out     (sc_V_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Each output lane is floor(lane * full_scale / max), saturated; max of zero yields zero.
    function automatic logic [RES_W-1:0] scaleRef(input logic [VEC_W-1:0] v, input logic [MAX_WIDTH-1:0] m);
        logic [RES_W-1:0] r;
        int lane;
        int q;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            lane = int'(v[l*IN_WIDTH +: IN_WIDTH]);
            q = (m == '0) ? 0 : (lane * OUT_MAX) / int'(m);
            if (q > OUT_MAX) q = OUT_MAX;
            r[l*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(q);
        end
        return r;
    endfunction

    function automatic int refPick(input logic [NUM_REQ-1:0] r);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (refPtr + k) % NUM_REQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int id);
        logic [NUM_REQ-1:0] o;
        o = '0;
        o[id] = 1'b1;
        return o;
    endfunction

    // Scaler stand-in: done pulses two cycles after start is seen, using the latched V_in.
    initial begin
        sc_done  = 1'b0;
        sc_V_out = '0;
        scCnt    = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sc_done = 1'b0;
                scCnt   = 0;
            end else begin
                sc_done = 1'b0;
                if (sc_start && !scStub) begin
                    scCnt = 2;
                end else if (scCnt > 0) begin
                    scCnt = scCnt - 1;
                    if (scCnt == 0) begin
                        sc_done  = 1'b1;
                        sc_V_out = scaleRef(sc_V_in, sc_max_value);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] reqBits);
        bus.req = reqBits;
    endtask

    task automatic randomizeRequester(input int id);
        for (int l = 0; l < LANES; l++)
            bus.req_vec[id*VEC_W + l*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'($urandom_range(0, (1 << IN_WIDTH) - 1));
        bus.req_max[id*MAX_WIDTH +: MAX_WIDTH] = MAX_WIDTH'($urandom_range(1, (1 << MAX_WIDTH) - 1));
    endtask

    // Called at the negedge where req was just applied in IDLE; returns at the following IDLE cycle.
    task automatic serveOne(input int expId);
        logic [VEC_W-1:0]     expIn;
        logic [MAX_WIDTH-1:0] expMax;
        logic [RES_W-1:0]     expVec;
        expIn  = bus.req_vec[expId*VEC_W +: VEC_W];
        expMax = bus.req_max[expId*MAX_WIDTH +: MAX_WIDTH];
        expVec = scaleRef(expIn, expMax);
        refPtr = expId;
        @(negedge clk);
        checkOutput("ack", 64'(bus.ack), 64'(onehot(expId)));
        checkOutput("sc_start", 64'(sc_start), 64'd1);
        checkOutput("sc_V_in", 64'(sc_V_in), 64'(expIn));
        checkOutput("sc_max_value", 64'(sc_max_value), 64'(expMax));
        applyStimulus('0);
        @(negedge clk);
        checkOutput("ack_pulse", 64'(bus.ack), 64'd0);
        checkOutput("busy", 64'(busy), 64'd1);
        @(negedge clk);
        checkOutput("resp_early", 64'(bus.resp_valid), 64'd0);
        @(negedge clk);
        checkOutput("resp_valid", 64'(bus.resp_valid), 64'd1);
        checkOutput("resp_id", 64'(bus.resp_id), 64'(expId));
        checkOutput("resp_vec", 64'(bus.resp_vec), 64'(expVec));
        checkOutput("no_err", 64'(err_timeout), 64'd0);
        lastRespVec = bus.resp_vec;
        @(negedge clk);
        checkOutput("resp_done", 64'(bus.resp_valid), 64'd0);
        checkOutput("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        refPtr = NUM_REQ - 1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int id;
        int lastAck;
        int acks;
        int pendId;
        int errCount;
        int errAt;
        int order [5];
        logic [RES_W-1:0] holdVec;

        testCount = 0;
        failCount = 0;
        refPtr    = NUM_REQ - 1;
        scStub    = 1'b0;
        reset     = 1'b0;
        bus.req        = '0;
        bus.req_vec    = '0;
        bus.req_max    = '0;
        bus.resp_ready = 1'b1;
        order = '{0, 1, 2, 3, 0};

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_ack", 64'(bus.ack), 64'd0);
        checkOutput("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_err", 64'(err_timeout), 64'd0);
        checkOutput("rst_sc_start", 64'(sc_start), 64'd0);
        checkOutput("rst_resp_id", 64'(bus.resp_id), 64'd0);
        checkOutput("rst_resp_vec", 64'(bus.resp_vec), 64'd0);
        checkOutput("rst_sc_V_in", 64'(sc_V_in), 64'd0);
        checkOutput("rst_sc_max", 64'(sc_max_value), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed single request, requester 0
        bus.req_vec[0 +: VEC_W] = {12'h100, 12'h200, 12'h400, 12'h800};
        bus.req_max[0 +: MAX_WIDTH] = 12'h800;
        applyStimulus(4'b0001);
        serveOne(refPick(bus.req));
        checkOutput("directed_literal", 64'(lastRespVec), 64'h137F);

        // Zero vector from requester 2
        bus.req_vec[2*VEC_W +: VEC_W] = '0;
        bus.req_max[2*MAX_WIDTH +: MAX_WIDTH] = 12'h123;
        applyStimulus(4'b0100);
        id = refPick(bus.req);
        checkOutput("zero_pick", 64'(id), 64'd2);
        serveOne(id);
        checkOutput("zero_literal", 64'(lastRespVec), 64'h0000);

        // Randomized request patterns and payloads
        for (int t = 0; t < 8; t++) begin
            for (int r = 0; r < NUM_REQ; r++) randomizeRequester(r);
            applyStimulus(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)));
            serveOne(refPick(bus.req));
        end

        // Fairness with all requests held high
        doReset();
        for (int r = 0; r < NUM_REQ; r++) randomizeRequester(r);
        applyStimulus('1);
        lastAck = -1;
        acks = 0;
        pendId = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bus.ack != '0) begin
                if (acks < 5) checkOutput("fair_ack", 64'(bus.ack), 64'(onehot(order[acks])));
                if (lastAck >= 0) checkOutput("fair_gap", 64'(c - lastAck), 64'd5);
                pendId  = refPick(bus.req);
                refPtr  = pendId;
                lastAck = c;
                acks++;
            end
            if (bus.resp_valid) begin
                checkOutput("fair_resp_id", 64'(bus.resp_id), 64'(pendId));
                checkOutput("fair_resp_vec", 64'(bus.resp_vec),
                    64'(scaleRef(bus.req_vec[pendId*VEC_W +: VEC_W], bus.req_max[pendId*MAX_WIDTH +: MAX_WIDTH])));
            end
        end
        checkOutput("fair_count", 64'(acks), 64'd5);
        applyStimulus('0);
        @(negedge clk);
        checkOutput("fair_idle", 64'(busy), 64'd0);

        // Backpressure: result held while resp_ready is low, requester 1 waits
        randomizeRequester(2);
        randomizeRequester(1);
        applyStimulus(4'b0100);
        id = refPick(bus.req);
        refPtr = id;
        holdVec = scaleRef(bus.req_vec[id*VEC_W +: VEC_W], bus.req_max[id*MAX_WIDTH +: MAX_WIDTH]);
        @(negedge clk);
        checkOutput("bp_ack", 64'(bus.ack), 64'(onehot(id)));
        applyStimulus(4'b0010);
        bus.resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            checkOutput("bp_valid", 64'(bus.resp_valid), 64'd1);
            checkOutput("bp_id", 64'(bus.resp_id), 64'(id));
            checkOutput("bp_vec", 64'(bus.resp_vec), 64'(holdVec));
            checkOutput("bp_no_ack", 64'(bus.ack), 64'd0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release", 64'(bus.resp_valid), 64'd0);
        checkOutput("bp_ack_wait", 64'(bus.ack), 64'd0);
        id = refPick(bus.req);
        checkOutput("bp_next_pick", 64'(id), 64'd1);
        serveOne(id);

        // Watchdog abort with a scaler that never finishes
        scStub = 1'b1;
        applyStimulus(4'b1000);
        id = refPick(bus.req);
        refPtr = id;
        @(negedge clk);
        checkOutput("to_ack", 64'(bus.ack), 64'(onehot(id)));
        applyStimulus('0);
        errCount = 0;
        errAt = -1;
        for (int j = 1; j <= TIMEOUT + 5; j++) begin
            @(negedge clk);
            if (err_timeout) begin
                errCount++;
                errAt = j;
            end
            checkOutput("to_no_resp", 64'(bus.resp_valid), 64'd0);
        end
        checkOutput("to_pulses", 64'(errCount), 64'd1);
        checkOutput("to_when", 64'(errAt), 64'(TIMEOUT + 1));
        checkOutput("to_idle", 64'(busy), 64'd0);
        scStub = 1'b0;
        randomizeRequester(0);
        applyStimulus(4'b0001);
        serveOne(refPick(bus.req));

        // Asynchronous reset while waiting for done
        scStub = 1'b1;
        applyStimulus(4'b0010);
        id = refPick(bus.req);
        @(negedge clk);
        checkOutput("ar_ack", 64'(bus.ack), 64'(onehot(id)));
        applyStimulus('0);
        repeat (2) @(negedge clk);
        checkOutput("ar_busy_before", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("ar_busy", 64'(busy), 64'd0);
        checkOutput("ar_sc_V_in", 64'(sc_V_in), 64'd0);
        checkOutput("ar_sc_max", 64'(sc_max_value), 64'd0);
        checkOutput("ar_resp_valid", 64'(bus.resp_valid), 64'd0);
        checkOutput("ar_err", 64'(err_timeout), 64'd0);
        refPtr = NUM_REQ - 1;
        @(negedge clk);
        reset = 1'b1;
        scStub = 1'b0;
        randomizeRequester(0);
        randomizeRequester(1);
        applyStimulus(4'b0011);
        id = refPick(bus.req);
        checkOutput("ar_pick", 64'(id), 64'd0);
        serveOne(id);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
